surf_cout_align: RTL and testbench

SURF_COUT_ALIGN -- requirements
Module: surf_cout_align

---
 rtl/surf_cout_align.sv | 245 ++++++++++++++++++++++++
 tb/tb_surf_cout_align.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/surf_cout_align.sv
// COUT/DOUT input-delay eye scan and word alignment for the SURF PHY.
// Define SURF_COUT_ALIGN_BITSLIP_EN to add the bitslip word-alignment stage after centring.
module surf_cout_align #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 64,
    parameter int MAX_TAP       = 31,
    parameter int MIN_EYE       = 4
) (
    input  logic       sysclk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       lane_i,
    input  logic [7:0] pattern_i,
    input  logic [3:0] cout_i,
    input  logic [7:0] dout_i,
    output logic [5:0] idelay_value_o,
    output logic       idelay_cout_load_o,
    output logic       idelay_dout_load_o,
    output logic       iserdes_rst_o,
    output logic       iserdes_cout_bitslip_o,
    output logic       iserdes_dout_bitslip_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fail_o,
    output logic [5:0] eye_start_o,
    output logic [6:0] eye_len_o
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] CHECK_LAST  = 16'(CHECK_CYCLES - 1);
    localparam logic [5:0]  TAP_LAST    = 6'(MAX_TAP);
    localparam logic [6:0]  EYE_MIN     = 7'(MIN_EYE);

`ifdef SURF_COUT_ALIGN_BITSLIP_EN
    typedef enum logic [3:0] {
        IDLE, RST, LOAD, SETTLE, CHECK, NEXT, PICK, CLOAD, CSETTLE, DONE, FAIL, SLIP, SWAIT
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, RST, LOAD, SETTLE, CHECK, NEXT, PICK, CLOAD, CSETTLE, DONE, FAIL
    } state_t;
`endif

    state_t      state_q, state_nxt;
    logic        lane_q, lane_nxt;
    logic [5:0]  tap_q, tap_nxt;
    logic [15:0] cnt_q, cnt_nxt;
    logic        tap_bad_q, tap_bad_nxt;
    logic [5:0]  cur_start_q, cur_start_nxt;
    logic [6:0]  cur_len_q, cur_len_nxt;
    logic [5:0]  best_start_q, best_start_nxt;
    logic [6:0]  best_len_q, best_len_nxt;
    logic        rst_hold_q;
    logic        word_ok;
    logic [5:0]  run_start;
    logic [6:0]  run_len;
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
    logic [3:0]  slip_q, slip_nxt;
    logic        slip_pulse;
    logic [3:0]  slip_limit;
`endif

    assign word_ok = lane_q ? (dout_i == pattern_i) : (cout_i == pattern_i[3:0]);

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            lane_q       <= 1'b0;
            tap_q        <= '0;
            cnt_q        <= '0;
            tap_bad_q    <= 1'b0;
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            rst_hold_q   <= 1'b1;
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
            slip_q       <= '0;
`endif
        end else begin
            state_q      <= state_nxt;
            lane_q       <= lane_nxt;
            tap_q        <= tap_nxt;
            cnt_q        <= cnt_nxt;
            tap_bad_q    <= tap_bad_nxt;
            cur_start_q  <= cur_start_nxt;
            cur_len_q    <= cur_len_nxt;
            best_start_q <= best_start_nxt;
            best_len_q   <= best_len_nxt;
            rst_hold_q   <= 1'b0;
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
            slip_q       <= slip_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state_q;
        lane_nxt       = lane_q;
        tap_nxt        = tap_q;
        cnt_nxt        = cnt_q;
        tap_bad_nxt    = tap_bad_q;
        cur_start_nxt  = cur_start_q;
        cur_len_nxt    = cur_len_q;
        best_start_nxt = best_start_q;
        best_len_nxt   = best_len_q;
        run_start      = (cur_len_q == 7'd0) ? tap_q : cur_start_q;
        run_len        = cur_len_q + 7'd1;
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
        slip_nxt       = slip_q;
        slip_pulse     = 1'b0;
        slip_limit     = lane_q ? 4'd8 : 4'd4;
`endif
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start_i) begin
                    lane_nxt       = lane_i;
                    tap_nxt        = '0;
                    cnt_nxt        = '0;
                    cur_start_nxt  = '0;
                    cur_len_nxt    = '0;
                    best_start_nxt = '0;
                    best_len_nxt   = '0;
                    state_nxt      = RST;
                end
            end
            RST: begin
                if (cnt_q == 16'd3) begin
                    cnt_nxt   = '0;
                    tap_nxt   = '0;
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt_q + 16'd1;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_nxt     = '0;
                    tap_bad_nxt = 1'b0;
                    state_nxt   = CHECK;
                end else begin
                    cnt_nxt = cnt_q + 16'd1;
                end
            end
            CHECK: begin
                if (!word_ok) tap_bad_nxt = 1'b1;
                if (cnt_q == CHECK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = NEXT;
                end else begin
                    cnt_nxt = cnt_q + 16'd1;
                end
            end
            NEXT: begin
                // Strict compare keeps the earliest of equally long runs.
                if (!tap_bad_q) begin
                    cur_start_nxt = run_start;
                    cur_len_nxt   = run_len;
                    if (run_len > best_len_q) begin
                        best_start_nxt = run_start;
                        best_len_nxt   = run_len;
                    end
                end else begin
                    cur_len_nxt = '0;
                end
                if (tap_q == TAP_LAST) begin
                    state_nxt = PICK;
                end else begin
                    tap_nxt   = tap_q + 6'd1;
                    state_nxt = LOAD;
                end
            end
            PICK: begin
                if (best_len_q < EYE_MIN) begin
                    state_nxt = FAIL;
                end else begin
                    tap_nxt   = best_start_q + best_len_q[6:1];
                    state_nxt = CLOAD;
                end
            end
            CLOAD: begin
                cnt_nxt   = '0;
                state_nxt = CSETTLE;
            end
            CSETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_nxt = '0;
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
                    slip_nxt  = '0;
                    state_nxt = SLIP;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt_q + 16'd1;
                end
            end
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
            SLIP: begin
                if (word_ok) begin
                    state_nxt = DONE;
                end else if (slip_q == slip_limit) begin
                    state_nxt = FAIL;
                end else begin
                    slip_pulse = 1'b1;
                    slip_nxt   = slip_q + 4'd1;
                    cnt_nxt    = '0;
                    state_nxt  = SWAIT;
                end
            end
            SWAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SLIP;
                end else begin
                    cnt_nxt = cnt_q + 16'd1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign idelay_value_o     = tap_q;
    assign idelay_cout_load_o = ((state_q == LOAD) || (state_q == CLOAD)) && !lane_q;
    assign idelay_dout_load_o = ((state_q == LOAD) || (state_q == CLOAD)) && lane_q;
    assign iserdes_rst_o      = rst_hold_q || (state_q == RST);
`ifdef SURF_COUT_ALIGN_BITSLIP_EN
    assign iserdes_cout_bitslip_o = slip_pulse && !lane_q;
    assign iserdes_dout_bitslip_o = slip_pulse && lane_q;
`else
    assign iserdes_cout_bitslip_o = 1'b0;
    assign iserdes_dout_bitslip_o = 1'b0;
`endif
    assign busy_o      = !((state_q == IDLE) || (state_q == DONE) || (state_q == FAIL));
    assign done_o      = (state_q == DONE);
    assign fail_o      = (state_q == FAIL);
    assign eye_start_o = best_start_q;
    assign eye_len_o   = best_len_q;

endmodule

// File: tb/tb_surf_cout_align.sv
// Directed bench for surf_cout_align: a PHY model passes data only inside chosen tap windows.
// Bitslip cases are compiled in when SURF_COUT_ALIGN_BITSLIP_EN is defined.
module tb_surf_cout_align;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       lane = 1'b0;
    logic [7:0] pattern = 8'h00;

    logic [3:0] cout0, cout1;
    logic [7:0] dout0, dout1;
    logic [5:0] value0, value1;
    logic       cload0, dload0, srst0, cslip0, dslip0, busy0, done0, fail0;
    logic       cload1, dload1, srst1, cslip1, dslip1, busy1, done1, fail1;
    logic [5:0] estart0, estart1;
    logic [6:0] elen0, elen1;

    int vectors = 0;
    int miscompares = 0;
    int win_lo0 = 63, win_hi0 = 0, win_lo1 = 63, win_hi1 = 0;
    int phase2_mode = 0;
    int load_cnt_c = 0, load_cnt_d = 0, slip_cnt_c = 0, slip_cnt_d = 0;
    int base_ld_c = 0, base_ld_d = 0, base_sl_c = 0, base_sl_d = 0;
    logic [5:0] last_load = '0;
    logic valid0, valid1;

    always #5 clk = ~clk;

    surf_cout_align dut0 (
        .sysclk_i(clk), .rst_n_i(rst_n), .start_i(start), .lane_i(lane),
        .pattern_i(pattern), .cout_i(cout0), .dout_i(dout0),
        .idelay_value_o(value0), .idelay_cout_load_o(cload0), .idelay_dout_load_o(dload0),
        .iserdes_rst_o(srst0), .iserdes_cout_bitslip_o(cslip0), .iserdes_dout_bitslip_o(dslip0),
        .busy_o(busy0), .done_o(done0), .fail_o(fail0),
        .eye_start_o(estart0), .eye_len_o(elen0)
    );

    surf_cout_align #(.MIN_EYE(5)) dut1 (
        .sysclk_i(clk), .rst_n_i(rst_n), .start_i(start), .lane_i(lane),
        .pattern_i(pattern), .cout_i(cout1), .dout_i(dout1),
        .idelay_value_o(value1), .idelay_cout_load_o(cload1), .idelay_dout_load_o(dload1),
        .iserdes_rst_o(srst1), .iserdes_cout_bitslip_o(cslip1), .iserdes_dout_bitslip_o(dslip1),
        .busy_o(busy1), .done_o(done1), .fail_o(fail1),
        .eye_start_o(estart1), .eye_len_o(elen1)
    );

    function automatic logic in_win(input int t, input int lo0, input int hi0,
                                    input int lo1, input int hi1);
        return (t >= lo0 && t <= hi0) || (t >= lo1 && t <= hi1);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    assign valid0 = in_win(int'(value0), win_lo0, win_hi0, win_lo1, win_hi1);
    assign valid1 = in_win(int'(value1), win_lo0, win_hi0, win_lo1, win_hi1);

    // After the centring load, mode 1 presents the word rotated by 3 minus slips so far; mode 2 never matches.
    always_comb begin
        cout0 = valid0 ? pattern[3:0] : ~pattern[3:0];
        dout0 = valid0 ? pattern : ~pattern;
        if ((load_cnt_d - base_ld_d) >= 33) begin
            if (phase2_mode == 1) dout0 = rotl(pattern, (3 - (slip_cnt_d - base_sl_d)) & 7);
            else if (phase2_mode == 2) dout0 = 8'h00;
        end
        cout1 = valid1 ? pattern[3:0] : ~pattern[3:0];
        dout1 = valid1 ? pattern : ~pattern;
    end

    always @(negedge clk) begin
        if (cload0) begin load_cnt_c++; last_load = value0; end
        if (dload0) begin load_cnt_d++; last_load = value0; end
        if (cslip0) slip_cnt_c++;
        if (dslip0) slip_cnt_d++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lane_sel, input logic [7:0] pat,
                                 input int lo0, input int hi0, input int lo1, input int hi1,
                                 input int mode);
        @(negedge clk);
        lane = lane_sel;
        pattern = pat;
        win_lo0 = lo0; win_hi0 = hi0; win_lo1 = lo1; win_hi1 = hi1;
        phase2_mode = mode;
        base_ld_c = load_cnt_c; base_ld_d = load_cnt_d;
        base_sl_c = slip_cnt_c; base_sl_d = slip_cnt_d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, busy0 | busy1}, 32'd0);
    endtask

    initial begin
        $display("[TB] reset checks");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_srst", srst0, 1);
        checkOutput("reset_busy", busy0, 0);
        checkOutput("reset_done_fail", {done0, fail0}, 0);
        checkOutput("reset_loads", {cload0, dload0, cslip0, dslip0}, 0);
        checkOutput("reset_value", value0, 0);
        checkOutput("reset_eye", {estart0, elen0}, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset_srst_held", srst0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_srst_release", srst0, 0);

        $display("[TB] DOUT window 10..20");
        applyStimulus(1'b1, 8'hA5, 10, 20, 63, 0, 0);
        checkOutput("dout_busy", busy0, 1);
        waitIdle("dout_finish");
        checkOutput("dout_done", {done0, fail0}, 2'b10);
        checkOutput("dout_eye_start", estart0, 10);
        checkOutput("dout_eye_len", elen0, 11);
        checkOutput("dout_final_tap", last_load, 15);
        checkOutput("dout_load_count", load_cnt_d - base_ld_d, 33);
        checkOutput("dout_cout_loads", load_cnt_c - base_ld_c, 0);
        checkOutput("dout_slips", slip_cnt_d - base_sl_d, 0);
        checkOutput("dout_min5_done", {done1, fail1}, 2'b10);

        $display("[TB] COUT two runs 2..6 and 20..24");
        applyStimulus(1'b0, 8'h3C, 2, 6, 20, 24, 0);
        waitIdle("cout_finish");
        checkOutput("cout_done", {done0, fail0}, 2'b10);
        checkOutput("cout_eye_start", estart0, 2);
        checkOutput("cout_eye_len", elen0, 5);
        checkOutput("cout_final_tap", last_load, 4);
        checkOutput("cout_load_count", load_cnt_c - base_ld_c, 33);
        checkOutput("cout_dout_pulses", (load_cnt_d - base_ld_d) + (slip_cnt_d - base_sl_d), 0);

        $display("[TB] all taps bad");
        applyStimulus(1'b1, 8'hA5, 63, 0, 63, 0, 0);
        waitIdle("allbad_finish");
        checkOutput("allbad_fail", {done0, fail0}, 2'b01);
        checkOutput("allbad_eye_len", elen0, 0);
        checkOutput("allbad_loads", load_cnt_d - base_ld_d, 32);

        $display("[TB] run at 28..31");
        applyStimulus(1'b1, 8'h5E, 28, 31, 63, 0, 0);
        waitIdle("edge_finish");
        checkOutput("edge_done", {done0, fail0}, 2'b10);
        checkOutput("edge_eye", {26'd0, estart0}, 28);
        checkOutput("edge_eye_len", elen0, 4);
        checkOutput("edge_final_tap", last_load, 30);
        checkOutput("edge_min5_fail", {done1, fail1}, 2'b01);
        checkOutput("edge_min5_eye_len", elen1, 4);

`ifdef SURF_COUT_ALIGN_BITSLIP_EN
        $display("[TB] word rotated by 3");
        applyStimulus(1'b1, 8'hA5, 10, 20, 63, 0, 1);
        waitIdle("rot3_finish");
        checkOutput("rot3_done", {done0, fail0}, 2'b10);
        checkOutput("rot3_slips", slip_cnt_d - base_sl_d, 3);
        checkOutput("rot3_cout_slips", slip_cnt_c - base_sl_c, 0);

        $display("[TB] word never matches");
        applyStimulus(1'b1, 8'hA5, 10, 20, 63, 0, 2);
        waitIdle("never_finish");
        checkOutput("never_fail", {done0, fail0}, 2'b01);
        checkOutput("never_slips", slip_cnt_d - base_sl_d, 8);
        checkOutput("never_cout_slips", slip_cnt_c - base_sl_c, 0);
`endif

        $display("[TB] reset during scan");
        applyStimulus(1'b1, 8'hA5, 10, 20, 63, 0, 0);
        repeat (30) @(negedge clk);
        checkOutput("midscan_busy", busy0, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy0, 0);
        checkOutput("midrst_srst", srst0, 1);
        checkOutput("midrst_status", {done0, fail0, cload0, dload0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_release", {srst0, busy0}, 0);

        $display("[TB] start while busy");
        applyStimulus(1'b1, 8'hA5, 10, 20, 63, 0, 0);
        repeat (100) @(negedge clk);
        lane = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busystart_no_restart", {srst0, busy0}, 2'b01);
        waitIdle("busystart_finish");
        checkOutput("busystart_done", {done0, fail0}, 2'b10);
        checkOutput("busystart_eye", {estart0, elen0}, {6'd10, 7'd11});
        checkOutput("busystart_cout_loads", load_cnt_c - base_ld_c, 0);
        checkOutput("busystart_final_tap", last_load, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
